// File: rtl/debug_port_v2.sv
// Host-to-CPU debug bridge: async 8-bit host register file synchronised into CLK, CPU control/capture, REQ/ACK FSM.
// Latency: host write commits 3 CLK after WRN rises; reads are combinational on DEBUG_ADDR.
// Backpressure: none on the host side; a request strobe while a request is outstanding is dropped.
//
// Ports:
//   CLK, RESETN (sync, active low)          - CPU clock and block reset
//   DEBUG_DIN/DOUT/ADDR/WRN/RDN              - asynchronous host register interface
//   RESET, DEBUG_STOP/MODE/OP                - CPU control outputs
//   DEBUG_ADDR_OUT, DEBUG_DATA_OUT           - CPU address / write data
//   DEBUG_ADDR_INC_EN, DEBUG_LD_*_EN         - CPU-side address step and capture strobes
//   DEBUG_DATAX, DEBUG_SRC_DATA, DEBUG_ARG_DATA - capture sources
//   DEBUG_REQ, DEBUG_ACK                     - request handshake to the CPU phase decoder
module debug_port_v2 #(
  parameter int ADDR_WIDTH     = 16,
  parameter int SRC_COUNT      = 5,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RESET_CYCLES   = 4,
  parameter int ADDR_STEP      = 2
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [7:0]              DEBUG_DIN,
  output logic [7:0]              DEBUG_DOUT,
  input  logic [3:0]              DEBUG_ADDR,
  input  logic                    DEBUG_WRN,
  input  logic                    DEBUG_RDN,
  output logic                    RESET,
  output logic                    DEBUG_STOP,
  output logic                    DEBUG_MODE,
  output logic [4:0]              DEBUG_OP,
  output logic [ADDR_WIDTH-1:0]   DEBUG_ADDR_OUT,
  output logic [15:0]             DEBUG_DATA_OUT,
  input  logic                    DEBUG_ADDR_INC_EN,
  input  logic                    DEBUG_LD_DATA_EN,
  input  logic                    DEBUG_LD_ARG_EN,
  input  logic [2:0]              DEBUG_DATAX,
  input  logic [16*SRC_COUNT-1:0] DEBUG_SRC_DATA,
  input  logic [15:0]             DEBUG_ARG_DATA,
  output logic                    DEBUG_REQ,
  input  logic                    DEBUG_ACK
);

  typedef enum logic [0:0] {S_IDLE, S_REQ} state_t;

  // host strobe synchronisers; stage 3 is the previous synchronised value for edge detect
  logic wrn_s1, wrn_s2, wrn_s3;
  logic rdn_s1, rdn_s2, rdn_s3;
  logic wr_fall, wr_commit, rd_fall, rd_commit;

  logic [7:0] wr_dat;
  logic [3:0] wr_addr;
  logic [3:0] rd_addr;

  logic                  stop_q, mode_q;
  logic [4:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_inc;
  logic [7:0]            dl_q, dh_q;
  logic [7:0]            rst_cnt;
  logic                  rst_active;

  state_t      state_q;
  logic        req_q;
  logic [15:0] timer_q;
  logic        timeout_q;

  logic [15:0] rdata_q, arg_q, src_word;
  logic        rdvalid_q, overrun_q;

  logic        wr_mode, wr_op, wr_al, wr_ah, wr_dl, wr_dh, wr_status;
  logic        req_strobe, rd_hi_clear;
  logic [15:0] addr_ext;
  logic [7:0]  status;

  // Synchronisers idle at the strobes' inactive (high) level so reset release
  // does not look like a host edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wrn_s1 <= 1'b1; wrn_s2 <= 1'b1; wrn_s3 <= 1'b1;
      rdn_s1 <= 1'b1; rdn_s2 <= 1'b1; rdn_s3 <= 1'b1;
    end else begin
      wrn_s1 <= DEBUG_WRN; wrn_s2 <= wrn_s1; wrn_s3 <= wrn_s2;
      rdn_s1 <= DEBUG_RDN; rdn_s2 <= rdn_s1; rdn_s3 <= rdn_s2;
    end
  end

  assign wr_fall   =  wrn_s3 & ~wrn_s2;
  assign wr_commit = ~wrn_s3 &  wrn_s2;
  assign rd_fall   =  rdn_s3 & ~rdn_s2;
  assign rd_commit = ~rdn_s3 &  rdn_s2;

  // Host address/data are sampled while the strobe is low, well after they settled.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      wr_dat  <= '0;
      wr_addr <= '0;
      rd_addr <= '0;
    end else begin
      if (wr_fall) begin
        wr_dat  <= DEBUG_DIN;
        wr_addr <= DEBUG_ADDR;
      end
      if (rd_fall) rd_addr <= DEBUG_ADDR;
    end
  end

  assign wr_mode   = wr_commit && (wr_addr == 4'h0);
  assign wr_op     = wr_commit && (wr_addr == 4'h1);
  assign wr_al     = wr_commit && (wr_addr == 4'h2);
  assign wr_ah     = wr_commit && (wr_addr == 4'h3);
  assign wr_dl     = wr_commit && (wr_addr == 4'h4);
  assign wr_dh     = wr_commit && (wr_addr == 4'h5);
  assign wr_status = wr_commit && (wr_addr == 4'hA);

  assign req_strobe  = (wr_mode && wr_dat[3]) || (wr_dh && op_q[0]);
  assign rd_hi_clear = rd_commit && (rd_addr == 4'h7);

  assign addr_inc = addr_q + ADDR_WIDTH'(ADDR_STEP);

  // CPU control registers; a host address load beats a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      stop_q <= 1'b0;
      mode_q <= 1'b0;
      op_q   <= '0;
      addr_q <= '0;
      dl_q   <= '0;
      dh_q   <= '0;
    end else begin
      if (wr_mode) begin
        stop_q <= wr_dat[0];
        mode_q <= wr_dat[1];
      end
      if (wr_op) op_q <= wr_dat[4:0];
      if (wr_al)
        addr_q[7:1] <= wr_dat[7:1];
      else if (wr_ah)
        addr_q[ADDR_WIDTH-1:8] <= wr_dat[ADDR_WIDTH-9:0];
      else if (DEBUG_ADDR_INC_EN)
        addr_q <= addr_inc & ~ADDR_WIDTH'(1);
      if (wr_dl) dl_q <= wr_dat;
      if (wr_dh) dh_q <= wr_dat;
    end
  end

  // CPU reset pulse; MODE[2] reads as "counter running" so it self-clears.
  always_ff @(posedge CLK) begin
    if (!RESETN)
      rst_cnt <= '0;
    else if (wr_mode && wr_dat[2])
      rst_cnt <= 8'(RESET_CYCLES);
    else if (rst_active)
      rst_cnt <= rst_cnt - 8'd1;
  end

  assign rst_active = (rst_cnt != 8'd0);

  // Request handshake. ACK beats timeout when both land on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (wr_status && wr_dat[2]) timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_strobe) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
            timer_q <= '0;
          end
        end
        S_REQ: begin
          if (DEBUG_ACK) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Out-of-range selects fall through to source 0.
  always_comb begin
    src_word = DEBUG_SRC_DATA[15:0];
    for (int i = 1; i < SRC_COUNT; i++) begin
      if (DEBUG_DATAX == 3'(i)) src_word = DEBUG_SRC_DATA[16*i +: 16];
    end
  end

  // Capture path; a load in the same cycle as a clear keeps rdvalid set.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      rdata_q   <= '0;
      arg_q     <= '0;
      rdvalid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (rd_hi_clear || (wr_status && wr_dat[1])) rdvalid_q <= 1'b0;
      if (wr_status && wr_dat[3]) overrun_q <= 1'b0;
      if (DEBUG_LD_DATA_EN) begin
        rdata_q   <= src_word;
        rdvalid_q <= 1'b1;
        if (rdvalid_q) overrun_q <= 1'b1;
      end
      if (DEBUG_LD_ARG_EN) arg_q <= DEBUG_ARG_DATA;
    end
  end

  assign addr_ext = 16'(addr_q);
  assign status   = {3'b000, rst_active, overrun_q, timeout_q, rdvalid_q, req_q};

  always_comb begin
    DEBUG_DOUT = 8'h00;
    case (DEBUG_ADDR)
      4'h0: DEBUG_DOUT = {5'b0, rst_active, mode_q, stop_q};
      4'h1: DEBUG_DOUT = {3'b0, op_q};
      4'h2: DEBUG_DOUT = addr_ext[7:0];
      4'h3: DEBUG_DOUT = addr_ext[15:8];
      4'h4: DEBUG_DOUT = dl_q;
      4'h5: DEBUG_DOUT = dh_q;
      4'h6: DEBUG_DOUT = rdata_q[7:0];
      4'h7: DEBUG_DOUT = rdata_q[15:8];
      4'h8: DEBUG_DOUT = arg_q[7:0];
      4'h9: DEBUG_DOUT = arg_q[15:8];
      4'hA: DEBUG_DOUT = status;
      default: DEBUG_DOUT = 8'h00;
    endcase
  end

  assign RESET          = ~RESETN | rst_active;
  assign DEBUG_STOP     = stop_q;
  assign DEBUG_MODE     = mode_q;
  assign DEBUG_OP       = op_q;
  assign DEBUG_ADDR_OUT = addr_q;
  assign DEBUG_DATA_OUT = {dh_q, dl_q};
  assign DEBUG_REQ      = req_q;

endmodule

// File: tb/tb_debug_port_v2.sv
// Directed bench for debug_port_v2 with hand-computed expected values.
module tb_debug_port_v2;
  localparam int AW  = 16;
  localparam int SC  = 5;
  localparam int TMO = 8;
  localparam int RC  = 4;

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [7:0]    DEBUG_DIN;
  logic [7:0]    DEBUG_DOUT;
  logic [3:0]    DEBUG_ADDR;
  logic          DEBUG_WRN, DEBUG_RDN;
  logic          RESET, DEBUG_STOP, DEBUG_MODE;
  logic [4:0]    DEBUG_OP;
  logic [AW-1:0] DEBUG_ADDR_OUT;
  logic [15:0]   DEBUG_DATA_OUT;
  logic          DEBUG_ADDR_INC_EN, DEBUG_LD_DATA_EN, DEBUG_LD_ARG_EN;
  logic [2:0]    DEBUG_DATAX;
  logic [16*SC-1:0] DEBUG_SRC_DATA;
  logic [15:0]   DEBUG_ARG_DATA;
  logic          DEBUG_REQ, DEBUG_ACK;

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  debug_port_v2 #(
    .ADDR_WIDTH(AW), .SRC_COUNT(SC), .TIMEOUT_CYCLES(TMO), .RESET_CYCLES(RC), .ADDR_STEP(2)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .DEBUG_DIN(DEBUG_DIN), .DEBUG_DOUT(DEBUG_DOUT), .DEBUG_ADDR(DEBUG_ADDR),
    .DEBUG_WRN(DEBUG_WRN), .DEBUG_RDN(DEBUG_RDN),
    .RESET(RESET), .DEBUG_STOP(DEBUG_STOP), .DEBUG_MODE(DEBUG_MODE), .DEBUG_OP(DEBUG_OP),
    .DEBUG_ADDR_OUT(DEBUG_ADDR_OUT), .DEBUG_DATA_OUT(DEBUG_DATA_OUT),
    .DEBUG_ADDR_INC_EN(DEBUG_ADDR_INC_EN), .DEBUG_LD_DATA_EN(DEBUG_LD_DATA_EN),
    .DEBUG_LD_ARG_EN(DEBUG_LD_ARG_EN), .DEBUG_DATAX(DEBUG_DATAX),
    .DEBUG_SRC_DATA(DEBUG_SRC_DATA), .DEBUG_ARG_DATA(DEBUG_ARG_DATA),
    .DEBUG_REQ(DEBUG_REQ), .DEBUG_ACK(DEBUG_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    DEBUG_ADDR = a;
    #1;
    check(tag, {24'h0, DEBUG_DOUT}, {24'h0, exp});
  endtask

  // Returns one cycle after the commit edge; inc raises INC_EN on that edge.
  task automatic host_write(input logic [3:0] a, input logic [7:0] d, input bit inc = 1'b0);
    DEBUG_ADDR = a;
    DEBUG_DIN  = d;
    DEBUG_WRN  = 1'b0;
    tick(3);
    DEBUG_WRN  = 1'b1;
    tick(2);
    if (inc) DEBUG_ADDR_INC_EN = 1'b1;
    tick(1);
    DEBUG_ADDR_INC_EN = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a);
    DEBUG_ADDR = a;
    DEBUG_RDN  = 1'b0;
    tick(3);
    DEBUG_RDN  = 1'b1;
    tick(3);
  endtask

  // Counts consecutive falling-edge samples with the chosen output high (0: REQ, 1: RESET).
  task automatic measure(input bit sel, output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if ((sel ? RESET : DEBUG_REQ) === 1'b1) cnt++;
      else break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0; DEBUG_DIN = '0; DEBUG_ADDR = '0; DEBUG_WRN = 1'b1; DEBUG_RDN = 1'b1;
    DEBUG_ADDR_INC_EN = 1'b0; DEBUG_LD_DATA_EN = 1'b0; DEBUG_LD_ARG_EN = 1'b0;
    DEBUG_DATAX = '0; DEBUG_ARG_DATA = '0; DEBUG_ACK = 1'b0;
    DEBUG_SRC_DATA = {16'h5555, 16'hBEEF, 16'h3333, 16'h2222, 16'hC3A5};
    tick(2);
    check("rst_req",   {31'h0, DEBUG_REQ}, 32'h0);
    check("rst_addr",  {16'h0, DEBUG_ADDR_OUT}, 32'h0);
    check("rst_reset", {31'h0, RESET}, 32'h1);
    check("rst_data",  {16'h0, DEBUG_DATA_OUT}, 32'h0);
    check_rd("rst_status", 4'hA, 8'h00);
    RESETN = 1'b1;
    tick(1);
    check("reset_release", {31'h0, RESET}, 32'h0);

    // address counter
    host_write(4'h2, 8'hFF);
    check("al_bit0", {16'h0, DEBUG_ADDR_OUT}, 32'h00FE);
    host_write(4'h3, 8'h12);
    check("addr_load", {16'h0, DEBUG_ADDR_OUT}, 32'h12FE);
    DEBUG_ADDR_INC_EN = 1'b1; tick(3); DEBUG_ADDR_INC_EN = 1'b0;
    check("addr_inc3", {16'h0, DEBUG_ADDR_OUT}, 32'h1304);
    host_write(4'h3, 8'hFF);
    host_write(4'h2, 8'hFE);
    DEBUG_ADDR_INC_EN = 1'b1; tick(1); DEBUG_ADDR_INC_EN = 1'b0;
    check("addr_wrap", {16'h0, DEBUG_ADDR_OUT}, 32'h0000);
    host_write(4'h2, 8'h40, 1'b1);
    check("al_beats_inc", {16'h0, DEBUG_ADDR_OUT}, 32'h0040);

    // stop / mode bits
    host_write(4'h0, 8'h03);
    check("stop_out", {31'h0, DEBUG_STOP}, 32'h1);
    check("mode_out", {31'h0, DEBUG_MODE}, 32'h1);
    check_rd("mode_rd", 4'h0, 8'h03);
    host_write(4'h0, 8'h00);

    // request acknowledged after 5 cycles
    host_write(4'h1, 8'h01);
    check("op_out", {27'h0, DEBUG_OP}, 32'h01);
    host_write(4'h4, 8'h34);
    host_write(4'h5, 8'h12);
    check("data_out", {16'h0, DEBUG_DATA_OUT}, 32'h1234);
    check("req_rise", {31'h0, DEBUG_REQ}, 32'h1);
    check_rd("status_busy", 4'hA, 8'h01);
    tick(4);
    check("req_hold", {31'h0, DEBUG_REQ}, 32'h1);
    DEBUG_ACK = 1'b1; tick(1); DEBUG_ACK = 1'b0;
    check("req_fall_ack", {31'h0, DEBUG_REQ}, 32'h0);
    check_rd("status_ack", 4'hA, 8'h00);
    DEBUG_ACK = 1'b1; tick(2); DEBUG_ACK = 1'b0;
    check("ack_idle_req", {31'h0, DEBUG_REQ}, 32'h0);

    // timeout
    host_write(4'h5, 8'h12);
    measure(1'b0, n);
    check("req_width", n, TMO);
    check_rd("status_tmo", 4'hA, 8'h04);
    host_write(4'hA, 8'h04);
    check_rd("status_clr", 4'hA, 8'h00);

    // request via MODE strobe, aborted by RESETN
    host_write(4'h0, 8'h08);
    check("mode_strobe_req", {31'h0, DEBUG_REQ}, 32'h1);
    RESETN = 1'b0; tick(1); RESETN = 1'b1;
    check("midrst_req", {31'h0, DEBUG_REQ}, 32'h0);
    tick(1);
    check_rd("midrst_status", 4'hA, 8'h00);

    // capture
    DEBUG_DATAX = 3'd3;
    DEBUG_LD_DATA_EN = 1'b1; tick(1); DEBUG_LD_DATA_EN = 1'b0;
    check_rd("rd_lo", 4'h6, 8'hEF);
    check_rd("rd_hi", 4'h7, 8'hBE);
    check_rd("rdvalid_set", 4'hA, 8'h02);
    host_read(4'h7);
    check_rd("rdvalid_clr", 4'hA, 8'h00);
    DEBUG_LD_DATA_EN = 1'b1; tick(2); DEBUG_LD_DATA_EN = 1'b0;
    check_rd("overrun", 4'hA, 8'h0A);
    DEBUG_DATAX = 3'd6;
    DEBUG_LD_DATA_EN = 1'b1; tick(1); DEBUG_LD_DATA_EN = 1'b0;
    check_rd("sel_oob_lo", 4'h6, 8'hA5);
    check_rd("sel_oob_hi", 4'h7, 8'hC3);
    host_write(4'hA, 8'h0E);
    check_rd("flags_clr", 4'hA, 8'h00);
    DEBUG_ARG_DATA = 16'h9876;
    DEBUG_LD_ARG_EN = 1'b1; tick(1); DEBUG_LD_ARG_EN = 1'b0;
    check_rd("arg_lo", 4'h8, 8'h76);
    check_rd("arg_hi", 4'h9, 8'h98);
    check_rd("arg_noflag", 4'hA, 8'h00);
    check_rd("unmapped", 4'hC, 8'h00);

    // CPU reset pulse
    host_write(4'h0, 8'h04);
    check_rd("rst_active", 4'hA, 8'h10);
    measure(1'b1, n);
    check("rst_width", n, RC);
    check_rd("mode_selfclr", 4'h0, 8'h00);

    // rewrite two cycles into the pulse: commits two edges apart
    tick(1);
    DEBUG_ADDR = 4'h0; DEBUG_DIN = 8'h04; DEBUG_WRN = 1'b0;
    tick(3);
    DEBUG_WRN = 1'b1; tick(1);
    DEBUG_WRN = 1'b0; tick(1);
    DEBUG_WRN = 1'b1; tick(1);
    measure(1'b1, n);
    check("rst_rewrite_width", n, RC + 2);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_port_v2.md
Name: debug_port_v2

Overview:
Second-generation CPU debug port: 8-bit asynchronous host register interface bridged into the CPU clock domain. Drives CPU control (stop, debug mode, op, address, write data) and captures CPU data for readback. Adds over the previous port:
- parametrised source-select channel count and address width;
- REQ/ACK handshake FSM with timeout;
- sticky status flags;
- self-timed debug reset pulse.

Parameters:
ADDR_WIDTH, 16, CPU address width (9..16); AH bits above ADDR_WIDTH-1 ignored, read back 0.
SRC_COUNT, 5, number of 16-bit capture sources on DEBUG_SRC_DATA (2..8).
TIMEOUT_CYCLES, 255, CLK cycles REQ may wait for ACK before abort (1..65535).
RESET_CYCLES, 4, length of host-commanded RESET pulse in CLK cycles (1..255).
ADDR_STEP, 2, address increment per DEBUG_ADDR_INC_EN pulse.

Ports:
CLK  in  1  CPU clock; all state on rising edge.
RESETN  in  1  synchronous, active-low reset.
DEBUG_DIN  in  8  host write data.
DEBUG_DOUT  out  8  host read data (combinational from DEBUG_ADDR).
DEBUG_ADDR  in  4  host register select.
DEBUG_WRN  in  1  host write strobe, active low, async to CLK.
DEBUG_RDN  in  1  host read strobe, active low, async to CLK.
RESET  out  1  CPU reset = ~RESETN OR reset-pulse active.
DEBUG_STOP  out  1  MODE[0].
DEBUG_MODE  out  1  MODE[1].
DEBUG_OP  out  5  op register.
DEBUG_ADDR_OUT  out  ADDR_WIDTH  CPU address; bit0 always 0.
DEBUG_DATA_OUT  out  16  CPU write data {DH,DL}.
DEBUG_ADDR_INC_EN  in  1  CPU pulse: address += ADDR_STEP.
DEBUG_LD_DATA_EN  in  1  capture selected source into read-data register.
DEBUG_LD_ARG_EN  in  1  capture DEBUG_ARG_DATA into arg register.
DEBUG_DATAX  in  3  source select; values >= SRC_COUNT select source 0.
DEBUG_SRC_DATA  in  16*SRC_COUNT  packed sources, source n at [16n+15:16n].
DEBUG_ARG_DATA  in  16  arg capture input.
DEBUG_REQ  out  1  request to CPU phase decoder.
DEBUG_ACK  in  1  CPU acknowledge.

Behaviour:
- Reset (RESETN=0 at edge): all registers 0.
  - Outputs: STOP/MODE/OP/ADDR_OUT/DATA_OUT/REQ = 0; RESET = 1.
  - FSM → IDLE; status flags clear.
- Host sync: WRN and RDN each pass through a 2-flop synchroniser.
  - Write commit on the synchronised rising edge of WRN, using DIN/ADDR registered at the synchronised falling edge.
  - Commit latency: 3 CLK after WRN rises.
  - Read side effect on the synchronised rising edge of RDN.
- Register map:
  - 0 MODE: W bits[2:0]={rst,mode,stop}; bit3=request strobe, not stored.
  - 1 OP: W 5 bits.
  - 2 AL: bits[7:1]; bit0 fixed 0.
  - 3 AH.
  - 4 DL.
  - 5 DH: write also issues a request if OP[0]=1.
  - 6/7 read-data low/high (R).
  - 8/9 arg low/high (R).
  - A STATUS (R): {3'b0, rst_active, overrun, timeout, rdvalid, busy}; write 1 to bits[3:1] clears them.
  - Unmapped addresses read 0; writes to them ignored.
- Address counter:
  - DEBUG_ADDR_INC_EN adds ADDR_STEP modulo 2^ADDR_WIDTH; wrap max→0 is silent.
  - A host AL/AH commit in the same cycle as INC_EN wins: loaded value, no increment.
- Request FSM: IDLE → REQ → IDLE.
  - IDLE: a request strobe moves to REQ; DEBUG_REQ=1 from the next cycle; busy=1; timer cleared.
  - REQ: DEBUG_ACK=1 returns to IDLE with REQ=0 the next cycle.
  - Timeout: timer reaches TIMEOUT_CYCLES without ACK → IDLE, REQ=0, timeout=1.
  - Request strobe while busy is ignored.
  - ACK while IDLE is ignored.
- Capture:
  - LD_DATA_EN loads the read-data register and sets rdvalid.
  - LD_DATA_EN while rdvalid=1 sets overrun sticky; data still overwritten.
  - Host read of addr 7 clears rdvalid; simultaneous LD wins (rdvalid stays 1).
  - LD_ARG_EN loads arg, no flags.
- Reset pulse:
  - MODE write with bit2=1 loads a counter with RESET_CYCLES; RESET=1 while the counter is nonzero, then MODE[2] self-clears.
  - Pulse resets only the CPU, not this block.
  - A rewrite during the pulse reloads the counter.
- Mid-operation RESETN: aborts any request next edge with REQ=0; no flag set.

Test Plan:
- RESETN low 2 cycles → REQ=0, ADDR_OUT=0, RESET=1, STATUS=0x00; RESETN high → RESET=0.
- Write AL=0xFE, AH=0x12, then 3 INC_EN pulses → ADDR_OUT=0x1304; with ADDR_WIDTH=16, start 0xFFFE plus 1 pulse → 0x0000.
- OP=0x01; DL=0x34, DH=0x12 → DATA_OUT=0x1234, REQ rises; ACK after 5 cycles → REQ falls next cycle, busy=0, timeout=0.
- TIMEOUT_CYCLES=8, request with no ACK → REQ high exactly 8 cycles, STATUS=0x04; write STATUS 0x04 → 0x00.
- SRC_COUNT=5, DATAX=3, source3=0xBEEF, LD_DATA_EN → reads addr6=0xEF, addr7=0xBE, rdvalid set then cleared; two LDs without read → overrun=1; DATAX=6 → source0 captured.
- MODE write 0x04 with RESET_CYCLES=4 → RESET high 4 cycles, then MODE reads 0x00; rewrite at cycle 2 → 6 cycles total.
